// File: rtl/irda_pkg.sv
// Shared definitions for the NEC IR key FIFO: register offsets, CTRL/STATUS
// bit positions, NEC frame field positions and the default repeat window.
package irda_pkg;

    // MMIO register map (2-bit word offset)
    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CTRL    = 2'd2,
        REG_REPEATS = 2'd3
    } reg_addr_e;

    // CTRL bits
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_RPT_EN = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_FLUSH  = 31;

    // STATUS bits
    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_COUNT_LSB = 2;
    localparam int unsigned STAT_OVF       = 15;

    // NEC frame fields: [7:0] addr, [15:8] addr_n/ext, [23:16] cmd, [31:24] ~cmd
    localparam int unsigned NEC_ADDR_LSB   = 0;
    localparam int unsigned NEC_ADDR_N_LSB = 8;
    localparam int unsigned NEC_CMD_LSB    = 16;
    localparam int unsigned NEC_CMD_N_LSB  = 24;
    localparam int unsigned NEC_FIELD_W    = 8;

    // 110 ms at 50 MHz
    localparam int unsigned REPEAT_WINDOW_DEFAULT = 5_500_000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO; wins over push/pop in the same cycle
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : current head entry
//   full/empty/count : occupancy
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (PTR_W+1)'(DEPTH));
        // a pop frees the slot, so full + pop + push is accepted
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    always_comb begin
        rdata = mem_q[rd_ptr_q];
        count = count_q;
    end

endmodule

// File: rtl/irda_key_fifo.sv
// NEC IR key FIFO: captures each validated receiver frame on the rising edge
// of the ready level, suppresses auto-repeats inside a time window, buffers
// frames and exposes DATA/STATUS/CTRL/REPEATS registers plus a level IRQ.
//   iCLK, iRST_n        : clock, asynchronous active-low reset
//   iDATA_READY, iDATA  : receiver ready level and 32-bit frame
//   iADDR, iRD_EN, iWR_EN, iWDATA : MMIO register access
//   oRDATA              : registered read data, holds until the next read
//   oIRQ                : IRQ_EN & (!empty | OVF), registered
module irda_key_fifo
    import irda_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PTR_W         = 3,
    parameter int unsigned REPEAT_WINDOW = REPEAT_WINDOW_DEFAULT,
    parameter int unsigned WIN_W         = 23
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    input  logic [1:0]  iADDR,
    input  logic        iRD_EN,
    input  logic        iWR_EN,
    input  logic [31:0] iWDATA,
    output logic [31:0] oRDATA,
    output logic        oIRQ
);

    logic             ready_q, ready_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      last_frame_q, last_frame_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [15:0]      rep_q, rep_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic             frame_evt;
    logic             is_repeat;
    logic             ctrl_wr;
    logic             flush;
    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;
    logic [31:0]      status_word;
    logic             unused_wdata;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (iCLK),
        .rst_n (iRST_n),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (iDATA),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        unused_wdata = ^iWDATA[30:3];

        frame_evt = iDATA_READY & ~ready_q & ctrl_q[CTRL_EN];
        is_repeat = frame_evt & ctrl_q[CTRL_RPT_EN] &
                    (iDATA == last_frame_q) & (win_q != '0);
        ctrl_wr   = iWR_EN & (iADDR == REG_CTRL);
        flush     = ctrl_wr & iWDATA[CTRL_FLUSH];
        fifo_push = frame_evt & ~is_repeat;
        fifo_pop  = iRD_EN & (iADDR == REG_DATA);

        ready_d      = iDATA_READY;
        ctrl_d       = ctrl_wr ? {iWDATA[CTRL_IRQ_EN], iWDATA[CTRL_RPT_EN], iWDATA[CTRL_EN]}
                               : ctrl_q;
        // last frame and window track every event, even with the filter off
        last_frame_d = frame_evt ? iDATA : last_frame_q;

        if (flush)               win_d = '0;
        else if (frame_evt)      win_d = WIN_W'(REPEAT_WINDOW);
        else if (win_q != '0)    win_d = win_q - 1'b1;
        else                     win_d = win_q;

        if (flush)                         rep_d = '0;
        else if (is_repeat && rep_q != '1) rep_d = rep_q + 1'b1;
        else                               rep_d = rep_q;

        // overflow only when the FIFO cannot make room by a same-cycle pop
        if (flush)                                             ovf_d = 1'b0;
        else if (fifo_push && fifo_full && !(fifo_pop && !fifo_empty)) ovf_d = 1'b1;
        else                                                   ovf_d = ovf_q;

        status_word                                 = '0;
        status_word[STAT_EMPTY]                     = fifo_empty;
        status_word[STAT_FULL]                      = fifo_full;
        status_word[STAT_COUNT_LSB +: PTR_W+1]      = fifo_count;
        status_word[STAT_OVF]                       = ovf_q;

        rdata_d = rdata_q;
        if (iRD_EN) begin
            case (reg_addr_e'(iADDR))
                REG_DATA:    rdata_d = fifo_empty ? '0 : fifo_head;
                REG_STATUS:  rdata_d = status_word;
                REG_CTRL:    rdata_d = {29'b0, ctrl_q};
                REG_REPEATS: rdata_d = {16'b0, rep_q};
                default:     rdata_d = '0;
            endcase
        end

        irq_d = ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | ovf_q);
    end

    // ready_q resets high so a level already present at reset release is ignored
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ready_q      <= 1'b1;
            ctrl_q       <= '0;
            last_frame_q <= '0;
            win_q        <= '0;
            rep_q        <= '0;
            ovf_q        <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            ctrl_q       <= ctrl_d;
            last_frame_q <= last_frame_d;
            win_q        <= win_d;
            rep_q        <= rep_d;
            ovf_q        <= ovf_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        oRDATA = rdata_q;
        oIRQ   = irq_q;
    end

endmodule
